// File: rtl/pet_vram_arbiter.sv
// PET video RAM arbiter: video fetch has absolute priority, CPU writes are
// posted through a one-entry buffer, CPU reads forward from that buffer.
module pet_vram_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          vid_conflict
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RD   = 2'd1,
    C_ACK  = 2'd2
  } cstate_t;

  cstate_t state;
  cstate_t state_nx;

  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  logic          rd_issued;
  logic [1:0]    rd_pipe;
  logic [1:0]    vid_pipe;

  logic drain;
  logic rd_pend;
  logic rd_issue;
  logic rd_done;
  logic idle_req;
  logic wr_acc;
  logic rd_hit;
  logic rd_acc;

  // Slot decisions all use the state sampled at this edge.
  always_comb begin
    drain    = wb_valid & ~vid_req;
    rd_pend  = (state == C_RD) & ~rd_issued;
    rd_issue = rd_pend & ~vid_req & ~wb_valid;
    rd_done  = rd_pipe[1];
    idle_req = (state == C_IDLE) & cpu_req;
    wr_acc   = idle_req & cpu_we & (~wb_valid | drain);
    rd_hit   = idle_req & ~cpu_we & wb_valid
             & (cpu_addr == wb_addr);
    rd_acc   = idle_req & ~cpu_we & ~rd_hit;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      C_IDLE: begin
        if (wr_acc || rd_hit)
          state_nx = C_ACK;
        else if (rd_acc)
          state_nx = C_RD;
      end
      C_RD: begin
        if (rd_done)
          state_nx = C_ACK;
      end
      C_ACK:   state_nx = C_IDLE;
      default: state_nx = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= C_IDLE;
    else
      state <= state_nx;
  end

  // A drain and a new capture may happen on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (wr_acc) begin
      wb_valid <= 1'b1;
      wb_addr  <= cpu_addr;
      wb_data  <= cpu_wdata;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else if (vid_req) begin
      ram_addr  <= vid_addr;
      ram_we    <= 1'b0;
    end else if (wb_valid) begin
      ram_addr  <= wb_addr;
      ram_we    <= 1'b1;
      ram_wdata <= wb_data;
    end else if (rd_pend) begin
      ram_addr  <= cpu_addr;
      ram_we    <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_issued <= 1'b0;
      rd_pipe   <= '0;
      vid_pipe  <= '0;
    end else begin
      if (rd_issue)
        rd_issued <= 1'b1;
      else if (rd_done)
        rd_issued <= 1'b0;
      rd_pipe  <= {rd_pipe[0], rd_issue};
      vid_pipe <= {vid_pipe[0], vid_req};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_valid    <= 1'b0;
      vid_data     <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      vid_conflict <= 1'b0;
    end else begin
      vid_valid    <= vid_pipe[1];
      if (vid_pipe[1])
        vid_data   <= ram_rdata;
      cpu_ack      <= (state_nx == C_ACK);
      if (rd_hit)
        cpu_rdata  <= wb_data;
      else if (rd_done)
        cpu_rdata  <= ram_rdata;
      vid_conflict <= vid_req & (wb_valid | rd_pend);
    end
  end

endmodule

// File: tb/tb_pet_vram_arbiter.sv
// Bench for pet_vram_arbiter: vector table, corner sequences and a
// randomized run against a program-order reference memory.
module tb_pet_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [10:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        vid_conflict;

  int total = 0;
  int bad   = 0;

  pet_vram_arbiter #(.AW(11), .DW(8)) dut (
    .clk(clk),
    .reset(reset),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .vid_valid(vid_valid),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .vid_conflict(vid_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Synchronous-read single-port VRAM, with bench preload ports.
  logic [7:0]  mem [2048];
  logic        ld_all;
  logic        ld_one;
  logic [10:0] ld_addr;
  logic [7:0]  ld_data;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 2048; i++)
        mem[i] <= pat(11'(i));
    end else begin
      if (ld_one)
        mem[ld_addr] <= ld_data;
      if (ram_we)
        mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  logic [7:0] ref_mem [2048];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Video monitor: every request must produce vid_valid exactly two
  // clocks later; video addresses used here are never written by the CPU.
  logic        mon_en;
  logic [2:0]  vh;
  logic [10:0] va0, va1, va2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vh  <= '0;
      va0 <= '0;
      va1 <= '0;
      va2 <= '0;
    end else begin
      vh  <= {vh[1:0], vid_req};
      va0 <= vid_addr;
      va1 <= va0;
      va2 <= va1;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset && (vid_valid || vh[2])) begin
      chk("vid_valid_latency", 64'(vid_valid), 64'(vh[2]));
      if (vh[2])
        chk("vid_data", 64'(vid_data), 64'(pat(va2)));
    end
  end

  task automatic cpu_op(input logic we, input logic [10:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output int lat);
    int n;
    n   = 0;
    rd  = '0;
    lat = -1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    while (lat < 0 && n < 200) begin
      tick();
      n++;
      if (cpu_ack) begin
        lat = n;
        rd  = cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL cpu_timeout: addr %0h no ack after %0d clocks", a, n);
    end else begin
      tick();
    end
  endtask

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  data;
    logic        hold;
    logic [7:0]  exp;
    int          lat;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [63:0] all_out();
    return 64'({vid_data, vid_valid, cpu_rdata, cpu_ack,
                ram_addr, ram_we, ram_wdata, vid_conflict});
  endfunction

  logic [7:0] rd;
  int         lat;
  int         nconf;
  int         ackat;
  int         acks;
  logic       rnd_done;

  initial begin
    tbl[0]  = '{1'b1, 11'h3E8, 8'hA5, 1'b0, 8'h00, 1};
    tbl[1]  = '{1'b0, 11'h3E8, 8'h00, 1'b0, 8'hA5, 4};
    tbl[2]  = '{1'b1, 11'h000, 8'h11, 1'b0, 8'h00, 1};
    tbl[3]  = '{1'b1, 11'h7FF, 8'hEE, 1'b0, 8'h00, 1};
    tbl[4]  = '{1'b0, 11'h7FF, 8'h00, 1'b0, 8'hEE, 4};
    tbl[5]  = '{1'b0, 11'h000, 8'h00, 1'b0, 8'h11, 4};
    tbl[6]  = '{1'b0, 11'h001, 8'h00, 1'b0, 8'h3D, 4};
    tbl[7]  = '{1'b1, 11'h200, 8'h77, 1'b1, 8'h00, 1};
    tbl[8]  = '{1'b0, 11'h200, 8'h00, 1'b1, 8'h77, 1};
    tbl[9]  = '{1'b0, 11'h201, 8'h00, 1'b0, 8'h3D, 4};
    tbl[10] = '{1'b0, 11'h200, 8'h00, 1'b0, 8'h77, 4};

    for (int i = 0; i < 2048; i++)
      ref_mem[i] = pat(11'(i));

    reset     = 1'b1;
    vid_req   = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ld_all    = 1'b1;
    ld_one    = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    mon_en    = 1'b0;
    rnd_done  = 1'b0;

    tick();
    ld_all = 1'b0;
    tick();
    chk("reset_outputs", all_out(), 64'd0);
    reset = 1'b0;
    tick();

    // Video fetch latency.
    ld_one  = 1'b1;
    ld_addr = 11'h000;
    ld_data = 8'h41;
    ref_mem[0] = 8'h41;
    tick();
    ld_one   = 1'b0;
    vid_req  = 1'b1;
    vid_addr = 11'h000;
    tick();
    vid_req = 1'b0;
    chk("vid_ram_port", 64'({ram_we, ram_addr}), 64'd0);
    chk("vid_valid_e0", 64'(vid_valid), 64'd0);
    tick();
    chk("vid_valid_e1", 64'(vid_valid), 64'd0);
    tick();
    chk("vid_valid_e2", 64'(vid_valid), 64'd1);
    chk("vid_data_e2", 64'(vid_data), 64'h41);
    tick();
    chk("vid_valid_e3", 64'(vid_valid), 64'd0);

    mon_en   = 1'b1;
    vid_addr = 11'h500;
    for (int i = 0; i < 11; i++) begin
      vid_req = tbl[i].hold;
      cpu_op(tbl[i].we, tbl[i].addr, tbl[i].data, rd, lat);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      if (tbl[i].we)
        ref_mem[tbl[i].addr] = tbl[i].data;
      else
        chk($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].exp));
    end
    vid_req = 1'b0;
    tick();
    chk("ram_3e8", 64'(mem[11'h3E8]), 64'hA5);

    // Pending read held off by three video edges.
    tick();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 11'h010;
    tick();
    nconf = 0;
    ackat = -1;
    rd    = '0;
    for (int i = 1; i <= 8; i++) begin
      vid_req = (i <= 3);
      tick();
      if (vid_conflict)
        nconf++;
      if (cpu_ack && ackat < 0) begin
        ackat   = i;
        rd      = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("conflict_count", 64'(nconf), 64'd3);
    chk("contended_ack", 64'(ackat), 64'd6);
    chk("contended_rdata", 64'(rd), 64'(ref_mem[11'h010]));

    // Second write stalls on a full buffer while video owns the port.
    vid_req = 1'b1;
    tick();
    cpu_op(1'b1, 11'h0A0, 8'h12, rd, lat);
    chk("wbfull_first_lat", 64'(lat), 64'd1);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 11'h0A1;
    cpu_wdata = 8'h34;
    acks = 0;
    repeat (4) begin
      tick();
      if (cpu_ack)
        acks++;
    end
    chk("wbfull_stall", 64'(acks), 64'd0);
    vid_req = 1'b0;
    tick();
    chk("wbfull_drain_accept", 64'(cpu_ack), 64'd1);
    cpu_req = 1'b0;
    repeat (3) tick();
    chk("ram_0a0", 64'(mem[11'h0A0]), 64'h12);
    chk("ram_0a1", 64'(mem[11'h0A1]), 64'h34);
    ref_mem[11'h0A0] = 8'h12;
    ref_mem[11'h0A1] = 8'h34;

    // Reset while a write sits in the buffer.
    vid_req = 1'b1;
    tick();
    cpu_op(1'b1, 11'h123, 8'h55, rd, lat);
    chk("rst_wr_lat", 64'(lat), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", all_out(), 64'd0);
    vid_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_no_write", 64'(mem[11'h123]), 64'(pat(11'h123)));
    cpu_op(1'b0, 11'h123, 8'h00, rd, lat);
    chk("rst_read_123", 64'(rd), 64'(ref_mem[11'h123]));

    // Randomized traffic.
    fork
      begin
        while (!rnd_done) begin
          vid_req  = ($urandom_range(0, 9) < 4);
          vid_addr = 11'h400 | 11'($urandom_range(0, 255));
          tick();
        end
        vid_req = 1'b0;
      end
      begin
        for (int k = 0; k < 300; k++) begin
          logic        w;
          logic [10:0] a;
          logic [7:0]  d;
          w = 1'($urandom_range(0, 1));
          a = 11'($urandom_range(0, 15));
          d = 8'($urandom_range(0, 255));
          cpu_op(w, a, d, rd, lat);
          if (lat > 0) begin
            if (w)
              ref_mem[a] = d;
            else
              chk("rnd_rdata", 64'(rd), 64'(ref_mem[a]));
          end
          repeat ($urandom_range(0, 2)) tick();
        end
        rnd_done = 1'b1;
      end
    join
    repeat (4) tick();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pet_vram_arbiter.md
Name: pet_vram_arbiter

Overview:
- Shares the single-port 2 KB video RAM between the video fetch path (character-matrix reads) and the 6502 CPU.
- Video reads have absolute priority and a fixed latency.
- CPU writes are posted through a one-entry write buffer. CPU reads use a req/ack handshake with read-after-write forwarding.
- Sits between the CPU bus decode, the video timing/fetch logic and the VRAM block.

Parameters:
- AW, 11, VRAM address width (2048 bytes).
- DW, 8, data width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- vid_req  in  1  one-clock fetch strobe from video timing.
- vid_addr  in  AW  matrix address, valid with vid_req.
- vid_data  out  DW  fetched byte.
- vid_valid  out  1  one-clock pulse; vid_data is valid.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  write data.
- cpu_rdata  out  DW  read data; valid while cpu_ack.
- cpu_ack  out  1  one-clock completion pulse.
- ram_addr  out  AW  VRAM address (registered).
- ram_we  out  1  VRAM write enable (registered).
- ram_wdata  out  DW  VRAM write data (registered).
- ram_rdata  in  DW  VRAM read data, one clock after the address edge (synchronous read).
- vid_conflict  out  1  one-clock pulse: a CPU operation wanted the RAM port this edge but video won.

Behaviour:
- Reset, asynchronous: every output is 0. Write buffer is emptied (contents discarded). CPU FSM goes to C_IDLE. Read pipeline valid bits are cleared. An in-flight video fetch is dropped; no vid_valid follows.
- Port slot: one RAM operation is issued per edge. Priority is evaluated on the inputs sampled at that edge:
  - 1. vid_req: read at vid_addr.
  - 2. Write buffer valid: write wb_addr/wb_data, then clear the buffer.
  - 3. CPU read accepted but not yet issued: read at cpu_addr.
  - 4. Otherwise ram_we=0 and ram_addr holds its last value.
- Video latency: vid_req sampled at edge E0, ram_addr driven E0..E1, ram_rdata captured at E2. vid_valid is high E2..E3.
  - Fixed at 2 clocks regardless of CPU activity.
  - Back-to-back vid_req is legal; each produces its own vid_valid.
- Video read data reflects RAM contents only. The write buffer is not forwarded to video; a buffered write becomes visible to video after it drains.
- CPU FSM states:
  - C_IDLE: cpu_req sampled high:
    - Write with buffer empty: capture into the buffer, go to C_ACK.
    - Write with buffer full: stay in C_IDLE; retry each edge.
    - Read whose address equals wb_addr with buffer valid: forward wb_data into cpu_rdata, go to C_ACK.
    - Read otherwise: go to C_RD (pending).
  - C_RD: waits for a free slot (priority 3). Issued at edge Ei; data captured at Ei+2 with cpu_ack high Ei+2..Ei+3, then back to C_IDLE.
    - The FSM stays in C_RD through the data cycle and ignores cpu_req.
  - C_ACK: cpu_ack high for one clock. cpu_req is ignored in this cycle. Return to C_IDLE.
- The requester drops or changes cpu_req during the ack cycle. A request still high at the edge after ack is treated as a new transaction.
- Simultaneous events:
  - CPU write accept and buffer drain on the same edge: legal. The drain frees the slot and the new write is captured in the same edge, because the full check uses the post-drain state.
  - Read miss while the buffer is valid: the buffer drains first (priority 2); the read issues on a later free slot.
  - Minimum CPU read latency (no contention): accept E0, issue E1, ack E3.
- vid_conflict: pulses for each edge where vid_req wins and either the write buffer was valid or a CPU read was pending unissued.
- Address compare uses the full AW bits. Addresses do not wrap; the caller masks them.

Test Plan:
- Reset mid-write: buffer holds 0x123/0x55, reset asserted → all outputs 0 immediately (asynchronous). After release, no RAM write occurs, and a read of 0x123 returns the previous RAM contents.
- Video latency: vid_req with vid_addr=0x000 at E0, RAM preloaded with 0x41 → ram_addr=0x000 and ram_we=0 during E0..E1; vid_valid=1 with vid_data=0x41 at E2 only.
- CPU write then read, same address: write 0x3E8←0xA5 acked 1 clock after accept; an immediate read of 0x3E8 is acked with 0xA5, either forwarded or after drain. RAM[0x3E8]=0xA5 afterwards.
- Contention: CPU read of 0x010 pending while vid_req is asserted on 3 consecutive edges → vid_conflict pulses 3 times. The CPU read issues on the 4th edge, and cpu_ack arrives 2 clocks later with the correct data.
- Buffer full: two back-to-back CPU writes while vid_req is held high → the second write is not acked until the first drains. Final RAM holds both values.
- Interleaved stress: random vid_req and CPU traffic against a reference memory model → every vid_valid arrives exactly 2 clocks after its request, and all CPU reads return model data.
